alu_req_scheduler: RTL
======================

// Module: alu_req_scheduler
// PURPOSE
//  Shares one combinational ALU datapath (add/sub/mul/div/mod; 16-bit operands, 32-bit result, 2-bit error)
//  between two requesters. Grants requesters round-robin and holds operands stable for ALU_LAT cycles.
//  Registers result and error, then returns them on a response channel with valid/ready handshake.
//  Sits between command sources and the ALU breadboard; it is the only driver of the ALU inputs.
// PARAMETERS
//  ALU_LAT  2  ALU settle cycles per op (>=1); operands held this many cycles before capture
//  CNT_W    8  width of completed-op counter done_cnt
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous active-low reset
//  req0_valid  in   1      requester 0 command valid
//  req0_ready  out  1      requester 0 command accepted this cycle
//  req0_a      in   16     requester 0 operand A
//  req0_b      in   16     requester 0 operand B
//  req0_op     in   4      requester 0 opcode: 0 add, 1 sub, 2 mul, 3 div, 4 mod
//  req1_*      same as req0_* for requester 1
//  alu_a       out  16     ALU operand A (registered)
//  alu_b       out  16     ALU operand B (registered)
//  alu_op      out  4      ALU opcode (registered)
//  alu_result  in   32     ALU result
//  alu_err     in   2      ALU error code
//  rsp_valid   out  1      response valid
//  rsp_ready   in   1      response consumer ready
//  rsp_id      out  1      requester that issued this response
//  rsp_data    out  32     captured result
//  rsp_err     out  2      00 ok, 01 illegal opcode, 10 div/mod by zero
//  busy        out  1      high whenever state != IDLE
//  done_cnt    out  CNT_W  count of completed responses; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; all outputs 0; last_id=1, so req0 wins the first tie.
//  FSM states: IDLE, WAIT, RESP.
//  IDLE:
//   - If no reqN_valid is high, stay in IDLE.
//   - Otherwise grant one requester: if exactly one is valid, grant it.
//   - If both are valid, grant the one != last_id.
//   - reqN_ready is combinational: high only in IDLE and only for the granted N. Acceptance = valid & ready.
//   - On acceptance, register a/b/op into alu_*, grant id into rsp_id, and set last_id = grant.
//   - Legal op (0-4): go to WAIT with cnt=ALU_LAT.
//   - Illegal op (5-15): go directly to RESP with rsp_data=0, rsp_err=01. The ALU is not waited on.
//  WAIT:
//   - Hold alu_* constant and decrement cnt each cycle.
//   - In the cycle cnt==1, capture into rsp_data/rsp_err at the clock edge, then go to RESP:
//     - op 3 or 4 with alu_b==0: rsp_data=0, rsp_err=10 (independent of alu_err).
//     - Otherwise: rsp_data=alu_result, rsp_err=alu_err.
//  RESP:
//   - rsp_valid=1. rsp_id, rsp_data and rsp_err stay stable until handshake.
//   - On rsp_valid & rsp_ready, go to IDLE, clear rsp_valid, and increment done_cnt (wrapping 2^CNT_W-1 -> 0).
//   - No new command is accepted in WAIT or RESP; reqN_ready=0.
//  Latency:
//   - Accept on edge T gives rsp_valid high from cycle T+ALU_LAT+1.
//   - Illegal op gives rsp_valid high from cycle T+1.
//   - Minimum issue interval is ALU_LAT+2 cycles with rsp_ready tied high.
//  Arithmetic: no width conversion here. The ALU sign/width rules apply; the data passes through unchanged.
//  Requester dropping valid before grant: no effect; arbitration is re-evaluated every IDLE cycle.
//  Reset mid-op: the in-flight op is discarded, no response is issued, and last_id returns to 1.
// TESTING
//  T1: req0 {a=11,b=15,op=0}, ALU_LAT=2, rsp_ready=1 -> req0_ready 1 cycle; rsp_valid at T+3;
//      rsp_data=26, rsp_err=00, rsp_id=0, done_cnt=1.
//  T2: req0 and req1 valid continuously with ops 2 {11,15} and 1 {32000,16000}
//      -> grants alternate 0,1,0,1; responses 165,16000,165,16000 with matching rsp_id.
//  T3: req1 {a=11,b=0,op=3}, then {11,0,op=4} -> rsp_data=0, rsp_err=10 for both.
//  T4: req0 op=7 -> rsp_valid at T+1, rsp_err=01, alu_op unchanged from previous op.
//  T5: rsp_ready held 0 for 10 cycles in RESP while req0/req1 valid
//      -> rsp_* stable, both readies 0, no new grant; release -> handshake then next grant.
//  T6: assert rst_n=0 during WAIT -> all outputs 0 immediately, no response;
//      then 2^CNT_W+1 ops -> done_cnt wraps to 1.

Source files
------------

// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one combinational ALU between two requesters; latency ALU_LAT+1 cycles (1 for illegal op).
// Backpressure: a response held by rsp_ready=0 stalls in RESP and blocks all new grants.
module alu_req_scheduler #(
  parameter int ALU_LAT = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [15:0]      req0_a,
  input  logic [15:0]      req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [15:0]      req1_a,
  input  logic [15:0]      req1_b,
  input  logic [3:0]       req1_op,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [3:0]       alu_op,
  input  logic [31:0]      alu_result,
  input  logic [1:0]       alu_err,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_data,
  output logic [1:0]       rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);
  localparam int LW = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic          last_id;
  logic          any_vld;
  logic          grant_id;
  logic          accept;
  logic          op_legal;
  logic          div_zero;
  logic          rsp_fire;
  logic [15:0]   sel_a;
  logic [15:0]   sel_b;
  logic [3:0]    sel_op;
  logic [LW-1:0] cnt;

  // On a tie the requester that was not served last wins.
  always_comb begin
    any_vld  = req0_valid | req1_valid;
    grant_id = (req0_valid & req1_valid) ? ~last_id : req1_valid;
    sel_a    = grant_id ? req1_a  : req0_a;
    sel_b    = grant_id ? req1_b  : req0_b;
    sel_op   = grant_id ? req1_op : req0_op;
    op_legal = (sel_op <= 4'd4);
    div_zero = ((alu_op == 4'd3) || (alu_op == 4'd4)) && (alu_b == 16'd0);
    accept   = (state == IDLE) && any_vld;
    rsp_fire = (state == RESP) && rsp_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        req0_ready = any_vld & ~grant_id;
        req1_ready = any_vld & grant_id;
        if (any_vld) begin
          state_nxt = op_legal ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt == LW'(1)) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Illegal opcodes never reach the ALU, so its inputs keep the last legal op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= '0;
      last_id  <= 1'b1;
      cnt      <= '0;
      done_cnt <= '0;
    end else begin
      if (accept) begin
        rsp_id  <= grant_id;
        last_id <= grant_id;
        if (op_legal) begin
          alu_a  <= sel_a;
          alu_b  <= sel_b;
          alu_op <= sel_op;
          cnt    <= LW'(ALU_LAT);
        end else begin
          rsp_data <= '0;
          rsp_err  <= 2'b01;
        end
      end
      if (state == WAIT) begin
        cnt <= cnt - LW'(1);
        if (cnt == LW'(1)) begin
          rsp_data <= div_zero ? 32'd0 : alu_result;
          rsp_err  <= div_zero ? 2'b10 : alu_err;
        end
      end
      if (rsp_fire) begin
        done_cnt <= done_cnt + CNT_W'(1);
      end
    end
  end

endmodule
